// File: rtl/fixed_multiply.sv
// -----------------------------------------------------------------------------
// fixed_multiply
//
// Sequential signed fixed-point multiplier for the ray-tracer arithmetic
// pipeline. It is the companion to the shared divider and uses the same Q
// format and the same valid_in/valid_out handshake.
//
//   product = round(multiplicand * multiplier / 2^Q_BITS), saturated to D_WIDTH
//
// Operation: the operands are converted to unsigned magnitudes. A radix-2
// shift-add loop then forms the 2*D_WIDTH-bit product, one multiplier bit per
// cycle. The sign is applied only after rounding. As a result, the rounding is
// symmetric: half rounds away from zero.
//
// Timing: an accept edge E gives a valid_out pulse in the cycle after edge
// E+D_WIDTH+1. ready_out is already high in that pulse cycle, so a new request
// can be accepted back-to-back. Throughput is one result per D_WIDTH+2 cycles.
//
// Ports
//   clock         in   1        rising-edge clock
//   reset         in   1        asynchronous, active-high; aborts any request
//   multiplicand  in   D_WIDTH  signed operand a, sampled on the accept edge
//   multiplier    in   D_WIDTH  signed operand b, sampled on the accept edge
//   valid_in      in   1        request; taken only while ready_out=1
//   ready_out     out  1        high when idle
//   product       out  D_WIDTH  signed result, held until the next result
//   overflow      out  1        product was saturated; changes with product
//   valid_out     out  1        one-cycle pulse marking a new product
// -----------------------------------------------------------------------------
module fixed_multiply #(
  parameter int Q_BITS  = 10,
  parameter int D_WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] multiplicand,
  input  logic [D_WIDTH-1:0] multiplier,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [D_WIDTH-1:0] product,
  output logic               overflow,
  output logic               valid_out
);

  localparam int ACC_W = 2 * D_WIDTH;
  // One extra bit holds the rounding increment, so nothing is truncated
  // before the shift.
  localparam int RND_W = ACC_W + 1;
  localparam int CNT_W = $clog2(D_WIDTH);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(D_WIDTH - 1);
  localparam logic [RND_W-1:0] HALF_LSB = RND_W'(1) << (Q_BITS - 1);
  // Largest positive result: 2^(D-1)-1.
  localparam logic [RND_W-1:0] MAX_POS_MAG = (RND_W'(1) << (D_WIDTH - 1)) - RND_W'(1);
  // Magnitude of the most negative result: 2^(D-1).
  localparam logic [RND_W-1:0] MAX_NEG_MAG = RND_W'(1) << (D_WIDTH - 1);
  localparam logic [D_WIDTH-1:0] SAT_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0] SAT_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FINISH
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  // |a| pre-shifted by cnt. Shifting by one each cycle gives |a| << cnt
  // without a barrel shifter.
  logic [ACC_W-1:0]   mcand_q;
  // |b| shifted right each cycle, so bit 0 is always bit cnt of |b|.
  logic [D_WIDTH-1:0] mplier_q;
  logic               neg_q;
  logic [D_WIDTH-1:0] product_q;
  logic               overflow_q;
  logic               valid_out_q;

  // Rounding and saturation results, used in the FINISH cycle.
  logic [RND_W-1:0]   rounded;
  logic [RND_W-1:0]   mag;
  logic [D_WIDTH-1:0] mag_lo;
  logic [D_WIDTH-1:0] product_d;
  logic               overflow_d;

  // Two's-complement magnitude held in D_WIDTH unsigned bits.
  // The minimum value -2^(D-1) maps to 2^(D-1), which still fits.
  function automatic logic [D_WIDTH-1:0] magnitude(input logic [D_WIDTH-1:0] v);
    return v[D_WIDTH-1] ? (~v + D_WIDTH'(1)) : v;
  endfunction

  // Round half away from zero on the magnitude, then saturate and apply sign.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    product_d  = '0;
    overflow_d = 1'b0;
    rounded    = {1'b0, acc_q} + HALF_LSB;
    mag        = rounded >> Q_BITS;
    mag_lo     = mag[D_WIDTH-1:0];
    if (!neg_q && (mag > MAX_POS_MAG)) begin
      product_d  = SAT_POS;
      overflow_d = 1'b1;
    end else if (neg_q && (mag > MAX_NEG_MAG)) begin
      product_d  = SAT_NEG;
      overflow_d = 1'b1;
    end else begin
      // A negative result with zero magnitude negates to 0, as required.
      product_d = neg_q ? (~mag_lo + D_WIDTH'(1)) : mag_lo;
    end
  end

  // Control and datapath state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      overflow_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments. Every right-hand side
      // therefore sees the pre-edge value, whatever the statement order.
      valid_out_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            mcand_q  <= {{D_WIDTH{1'b0}}, magnitude(multiplicand)};
            mplier_q <= magnitude(multiplier);
            neg_q    <= multiplicand[D_WIDTH-1] ^ multiplier[D_WIDTH-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // Largest sum is (2^(D-1))^2 = 2^(2D-2), which fits in ACC_W bits.
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= ST_FINISH;
          end
        end

        ST_FINISH: begin
          product_q   <= product_d;
          overflow_q  <= overflow_d;
          valid_out_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ready_out depends only on state, so it is high during the valid_out cycle.
  assign ready_out = (state_q == ST_IDLE);
  assign product   = product_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_out_q;

endmodule
